// File: rtl/rv32i_types.sv
// Shared types and geometry for the cache-line to burst-memory adapter.
package rv32i_types;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned BEAT_COUNT  = 4;
    localparam int unsigned BEAT_WIDTH  = 64;
    localparam int unsigned LINE_WIDTH  = BEAT_COUNT * BEAT_WIDTH;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned BEAT_IDX_W  = $clog2(BEAT_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } adapter_state_t;

    // Bit offset of beat k inside the line register.
    function automatic logic [7:0] beat_lsb(input logic [BEAT_IDX_W-1:0] k);
        return 8'(k) * 8'(BEAT_WIDTH);
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Converts single 256-bit line read/writeback requests into 4-beat
// 64-bit bursts towards memory. One transaction in flight at a time; the
// line register and beat counter are shared by the read and write paths.
module cacheline_adapter
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,

    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    adapter_state_t        state;
    adapter_state_t        next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic [BEAT_IDX_W-1:0] beat_q;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic                  unused_offset_bits;

    assign line_addr          = {dfp_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_offset_bits = ^dfp_addr[OFFSET_BITS-1:0];
    assign last_beat          = (beat_q == BEAT_IDX_W'(BEAT_COUNT - 1));

    // State register; reset drops any partially completed burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state command strobes.
    always_comb begin
        next_state = state;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        dfp_resp   = 1'b0;
        case (state)
            IDLE: begin
                // Writeback has priority; a simultaneous read is served afterwards.
                if (dfp_write) begin
                    next_state = WR_BURST;
                end else if (dfp_read) begin
                    next_state = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bmem_rvalid && last_beat) begin
                    next_state = RESP;
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                if (bmem_ready && last_beat) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                dfp_resp   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, read-beat assembly and beat counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            line_q <= '0;
            beat_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dfp_write) begin
                        addr_q <= line_addr;
                        line_q <= dfp_wdata;
                        beat_q <= '0;
                    end else if (dfp_read) begin
                        addr_q <= line_addr;
                        beat_q <= '0;
                    end
                end
                RD_WAIT: begin
                    if (bmem_rvalid) begin
                        line_q[beat_lsb(beat_q) +: BEAT_WIDTH] <= bmem_rdata;
                        beat_q <= beat_q + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bmem_addr  = addr_q;
    assign bmem_wdata = (state == WR_BURST) ? line_q[beat_lsb(beat_q) +: BEAT_WIDTH] : '0;
    assign dfp_rdata  = line_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: a driver issues line requests
// and queues expected beats/responses, a memory responder answers bursts,
// and a monitor checks every dfp_resp against the reference line store.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  dfp_addr = '0;
    logic         dfp_read = 1'b0;
    logic         dfp_write = 1'b0;
    logic [255:0] dfp_wdata = '0;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_resp_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: whole lines keyed by line index.
    logic [255:0] ref_mem [bit [26:0]];
    // Responder backing store: 64-bit words keyed by byte address.
    logic [63:0]  mem [bit [31:0]];

    function automatic logic [63:0] pat_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        if (ref_mem.exists(a[31:5])) return ref_mem[a[31:5]];
        for (int i = 0; i < 4; i++) l[64*i +: 64] = pat_word({a[31:5], 5'b0} + 32'(8 * i));
        return l;
    endfunction

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat_word(a);
    endfunction

    typedef struct { bit is_wr; logic [255:0] line; } resp_t;
    typedef struct { logic [31:0] a; logic [63:0] d; } beat_t;
    resp_t        exp_resp [$];
    beat_t        exp_wb   [$];
    logic [31:0]  exp_ra   [$];

    task automatic preload(input logic [31:0] a, input logic [255:0] l);
        ref_mem[a[31:5]] = l;
        for (int i = 0; i < 4; i++) mem[{a[31:5], 5'b0} + 32'(8 * i)] = l[64*i +: 64];
    endtask

    task automatic push_write(input logic [31:0] a, input logic [255:0] d);
        beat_t b;
        resp_t r;
        for (int i = 0; i < 4; i++) begin
            b.a = {a[31:5], 5'b0};
            b.d = d[64*i +: 64];
            exp_wb.push_back(b);
        end
        ref_mem[a[31:5]] = d;
        r.is_wr = 1'b1;
        r.line  = d;
        exp_resp.push_back(r);
    endtask

    task automatic push_read(input logic [31:0] a);
        resp_t r;
        exp_ra.push_back({a[31:5], 5'b0});
        r.is_wr = 1'b0;
        r.line  = ref_line(a);
        exp_resp.push_back(r);
    endtask

    // Responder controls: mode 0 random ready, 1 always ready with fixed
    // latency, 2 always ready except a stall on write beat 2.
    int mode = 0;
    int lat_max = 3;
    int fixed_lat = 0;
    int stall_left = 0;
    bit spurious_en = 1'b1;

    bit          rd_active = 1'b0;
    int          rd_delay = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_base = '0;
    int          wcnt = 0;
    bit          prev_racc = 1'b0;
    bit          prev_read = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_a = '0;
    logic [63:0] prev_d = '0;
    bit          rdy;
    beat_t       wb;

    // Memory responder: picks ready, checks command/beat protocol, serves read beats.
    always @(negedge clk) begin
        if (!rst) begin
            rd_active   = 1'b0;
            wcnt        = 0;
            prev_racc   = 1'b0;
            prev_read   = 1'b0;
            prev_stall  = 1'b0;
            bmem_ready  = 1'b0;
            bmem_rvalid = 1'b0;
        end else begin
            case (mode)
                1: rdy = 1'b1;
                2: begin
                    if (bmem_write && wcnt == 2 && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bmem_ready = rdy;

            if (bmem_read || bmem_write) chk("rw_exclusive", bmem_read && bmem_write, 0);
            if (prev_racc) chk("read_cmd_one_cycle", bmem_read, 0);
            if (prev_stall) begin
                chk("stall_strobe", bmem_write, 1);
                chk("stall_addr", bmem_addr, prev_a);
                chk("stall_data", bmem_wdata, prev_d);
            end
            if (bmem_read && !prev_read) chk("read_after_resp_gap", cyc >= last_resp_cyc + 2, 1);

            prev_racc  = bmem_read && rdy;
            prev_read  = bmem_read;
            prev_stall = bmem_write && !rdy;
            prev_a     = bmem_addr;
            prev_d     = bmem_wdata;

            if (bmem_write && rdy) begin
                if (exp_wb.size() == 0) begin
                    chk("unexpected_write_beat", 1, 0);
                end else begin
                    wb = exp_wb.pop_front();
                    chk("write_addr", bmem_addr, wb.a);
                    chk("write_data", bmem_wdata, wb.d);
                end
                mem[bmem_addr + 32'(8 * wcnt)] = bmem_wdata;
                wcnt = (wcnt + 1) % 4;
            end

            if (bmem_read && rdy) begin
                if (exp_ra.size() == 0) chk("unexpected_read_cmd", 1, 0);
                else chk("read_addr", bmem_addr, exp_ra.pop_front());
                rd_active   = 1'b1;
                rd_base     = bmem_addr;
                rd_cnt      = 0;
                rd_delay    = (mode == 0) ? $urandom_range(0, lat_max) : fixed_lat;
                bmem_rvalid = 1'b0;
            end else if (rd_active) begin
                if (rd_delay > 0) begin
                    rd_delay--;
                    bmem_rvalid = 1'b0;
                end else if (mode == 0 && $urandom_range(0, 3) == 0) begin
                    bmem_rvalid = 1'b0;
                end else begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = mem_rd(rd_base + 32'(8 * rd_cnt));
                    rd_cnt++;
                    if (rd_cnt == 4) rd_active = 1'b0;
                end
            end else if (spurious_en && $urandom_range(0, 2) == 0) begin
                bmem_rvalid = 1'b1;
                bmem_rdata  = {$urandom, $urandom};
            end else begin
                bmem_rvalid = 1'b0;
            end
        end
    end

    bit    prev_resp = 1'b0;
    resp_t got;

    // Response monitor: every dfp_resp pops one expected completion.
    always @(negedge clk) begin
        if (!rst) begin
            prev_resp = 1'b0;
        end else begin
            if (prev_resp) chk("resp_single_cycle", dfp_resp, 0);
            if (dfp_resp) begin
                last_resp_cyc = cyc;
                if (exp_resp.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    got = exp_resp.pop_front();
                    if (got.is_wr) chk("write_beats_done_at_resp", exp_wb.size(), 0);
                    else chk("read_line", dfp_rdata, got.line);
                end
            end
            prev_resp = dfp_resp;
        end
    end

    task automatic wait_resp(input string name, input bit perturb, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (dfp_resp) break;
            if (perturb && n == 1) begin
                dfp_addr  = $urandom;
                dfp_wdata = {8{$urandom}};
            end
            if (n >= 300) begin
                chk({name, "_timeout"}, 0, 1);
                break;
            end
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        int           n;
        logic [255:0] l;
        logic [31:0]  a;
        logic [31:0]  b;
        int           kind;
        int           next_kind;
        bit           b2b;
        bit           entered_b2b;

        repeat (3) @(negedge clk);
        chk("reset_dfp_resp", dfp_resp, 0);
        chk("reset_bmem_read", bmem_read, 0);
        chk("reset_bmem_write", bmem_write, 0);
        chk("reset_bmem_addr", bmem_addr, 0);
        chk("reset_bmem_wdata", bmem_wdata, 0);
        chk("reset_dfp_rdata", dfp_rdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed read with three idle cycles before the beats.
        mode = 1; fixed_lat = 3; spurious_en = 1'b0;
        preload(32'h0000_1220, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        push_read(32'h0000_1234);
        dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
        wait_resp("dir_read", 1'b0, n);
        dfp_read = 1'b0;
        @(negedge clk);

        // Directed writeback with a three-cycle stall on beat 2.
        mode = 2; stall_left = 3;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'(i);
        push_write(32'h8000_0040, l);
        dfp_addr = 32'h8000_0040; dfp_wdata = l; dfp_write = 1'b1;
        wait_resp("dir_write_stall", 1'b0, n);
        dfp_write = 1'b0;
        chk("stall_consumed", stall_left, 0);
        @(negedge clk);

        // Writeback latency with memory always ready.
        mode = 1;
        l = rand_line();
        push_write(32'h0000_0200, l);
        dfp_addr = 32'h0000_0200; dfp_wdata = l; dfp_write = 1'b1;
        wait_resp("dir_write_lat", 1'b1, n);
        dfp_write = 1'b0;
        chk("write_latency", n, 5);
        @(negedge clk);

        // Read and write together: writeback first, then the read.
        mode = 0; spurious_en = 1'b1;
        l = rand_line();
        push_write(32'h0000_0100, l);
        push_read(32'h0000_0100);
        dfp_addr = 32'h0000_0100; dfp_wdata = l; dfp_read = 1'b1; dfp_write = 1'b1;
        wait_resp("both_first", 1'b0, n);
        dfp_write = 1'b0;
        wait_resp("both_second", 1'b0, n);
        dfp_read = 1'b0;
        @(negedge clk);

        // Reset while the second read beat is being delivered.
        mode = 1; fixed_lat = 0; spurious_en = 1'b0;
        push_read(32'h0000_3000);
        dfp_addr = 32'h0000_3000; dfp_read = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_dfp_rdata", dfp_rdata, 0);
        chk("abort_bmem_addr", bmem_addr, 0);
        chk("abort_bmem_read", bmem_read, 0);
        chk("abort_bmem_write", bmem_write, 0);
        chk("abort_bmem_wdata", bmem_wdata, 0);
        chk("abort_dfp_resp", dfp_resp, 0);
        dfp_read = 1'b0;
        exp_resp.delete(); exp_wb.delete(); exp_ra.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        push_read(32'h0000_3008);
        dfp_addr = 32'h0000_3008; dfp_read = 1'b1;
        wait_resp("after_abort", 1'b0, n);
        dfp_read = 1'b0;
        @(negedge clk);

        // Back-to-back reads with dfp_read held through dfp_resp.
        mode = 0; spurious_en = 1'b1;
        push_read(32'h0000_0100);
        dfp_addr = 32'h0000_0100; dfp_read = 1'b1;
        wait_resp("b2b_first", 1'b0, n);
        push_read(32'h0000_3000);
        dfp_addr = 32'h0000_3000;
        wait_resp("b2b_second", 1'b0, n);
        dfp_read = 1'b0;
        @(negedge clk);

        // Random mix over a small set of lines so reads revisit writebacks.
        next_kind   = $urandom_range(0, 2);
        entered_b2b = 1'b0;
        for (int t = 0; t < 40; t++) begin
            kind = next_kind;
            if (!entered_b2b) begin
                mode      = $urandom_range(0, 1);
                fixed_lat = $urandom_range(0, 3);
                lat_max   = $urandom_range(0, 5);
            end
            b = $urandom;
            a = 32'h4000_0000 | (32'($urandom_range(0, 7)) << 5) | {27'b0, b[4:0]};
            l = rand_line();
            dfp_addr = a;
            case (kind)
                0: begin
                    push_read(a);
                    dfp_read = 1'b1; dfp_write = 1'b0;
                    wait_resp("rand_read", !entered_b2b, n);
                end
                1: begin
                    push_write(a, l);
                    dfp_wdata = l; dfp_write = 1'b1; dfp_read = 1'b0;
                    wait_resp("rand_write", 1'b1, n);
                end
                default: begin
                    push_write(a, l);
                    push_read(a);
                    dfp_wdata = l; dfp_write = 1'b1; dfp_read = 1'b1;
                    wait_resp("rand_both_w", 1'b0, n);
                    dfp_write = 1'b0;
                    wait_resp("rand_both_r", 1'b0, n);
                end
            endcase
            next_kind = $urandom_range(0, 2);
            b2b = (kind == 0) && (next_kind == 0) && ($urandom_range(0, 1) == 1);
            entered_b2b = b2b;
            if (!b2b) begin
                dfp_read  = 1'b0;
                dfp_write = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (10) @(negedge clk);
        chk("resp_queue_drained", exp_resp.size(), 0);
        chk("write_queue_drained", exp_wb.size(), 0);
        chk("read_cmd_queue_drained", exp_ra.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
